param_multicycle_cpu: RTL and testbench

Parametrised successor of the team's 16-bit multi-cycle processor. Data width and register count are configurable, and the register file holds 2^REG_AW registers with the top one as PC. Memory access uses a stallable req/ready handshake instead of fixed-latency timing, and the core runs continuously from a run start until a halt instruction. It sits between the instruction/data memory and the board-level top, replacing the hard-wired 16-bit core.

---
 rtl/param_multicycle_cpu.sv | 203 ++++++++++++++++++++
 tb/tb_param_multicycle_cpu.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_multicycle_cpu.sv
// Parametrised multi-cycle processor with a stallable req/ready memory port.
// The register file holds 2^REG_AW words; the top register is the PC.
module param_multicycle_cpu #(
  parameter int                DATA_W   = 16,
  parameter int                REG_AW   = 3,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              run,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              done,
  output logic              halted,
  output logic [DATA_W-1:0] pc
);

  localparam int                NREG   = 1 << REG_AW;
  localparam logic [REG_AW-1:0] PC_IDX = '1;
  localparam logic [DATA_W-1:0] DW     = DATA_W'(DATA_W);

  localparam logic [3:0] OP_MV   = 4'h0;
  localparam logic [3:0] OP_MVI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h4;
  localparam logic [3:0] OP_ST   = 4'h5;
  localparam logic [3:0] OP_MVNZ = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;
  localparam logic [3:0] OP_SLT  = 4'h8;
  localparam logic [3:0] OP_SLL  = 4'h9;
  localparam logic [3:0] OP_SRL  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC, S_IMM, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] rf [NREG];
  logic [DATA_W-1:0] ir, g;

  logic [3:0]        opcode;
  logic [REG_AW-1:0] rx, ry;
  logic [DATA_W-1:0] rx_val, ry_val, alu_res;

  logic              rf_we, pc_inc, ir_load, g_load;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              unused_ir_bits;

  // Instruction word: opcode in the top nibble, then rx, then ry; low bits ignored.
  assign opcode         = ir[DATA_W-1 -: 4];
  assign rx             = ir[DATA_W-5 -: REG_AW];
  assign ry             = ir[DATA_W-5-REG_AW -: REG_AW];
  assign unused_ir_bits = ^ir;

  assign rx_val = rf[rx];
  assign ry_val = rf[ry];
  assign pc     = rf[PC_IDX];
  assign halted = (state == S_HALT);

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = rx_val + ry_val;
      OP_SUB:  alu_res = rx_val - ry_val;
      OP_AND:  alu_res = rx_val & ry_val;
      OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (rx_val < ry_val)};
      OP_SLL:  alu_res = (ry_val >= DW) ? '0 : (rx_val << ry_val);
      OP_SRL:  alu_res = (ry_val >= DW) ? '0 : (rx_val >> ry_val);
      default: alu_res = '0;
    endcase
  end

  // Memory handshake: a request is live while mem_req=1; mem_addr, mem_we and
  // mem_wdata hold steady until the cycle mem_ready=1 completes it. mem_ready
  // without mem_req is ignored, and the memory may stall for any length.
  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    done      = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = rx;
    rf_wdata  = '0;
    pc_inc    = 1'b0;
    ir_load   = 1'b0;
    g_load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) begin
          ir_load   = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode)
          OP_MV: begin
            rf_we     = 1'b1;
            rf_wdata  = ry_val;
            done      = 1'b1;
            state_nxt = S_FETCH;
          end
          OP_MVNZ: begin
            rf_we     = (g != '0);
            rf_wdata  = ry_val;
            done      = 1'b1;
            state_nxt = S_FETCH;
          end
          OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL, OP_SRL: begin
            g_load    = 1'b1;
            state_nxt = S_WB;
          end
          OP_MVI:        state_nxt = S_IMM;
          OP_LD, OP_ST:  state_nxt = S_MEM;
          OP_HALT: begin
            done      = 1'b1;
            state_nxt = S_HALT;
          end
          default: begin
            done      = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_IMM: begin
        mem_req  = 1'b1;
        mem_addr = pc;
        if (mem_ready) begin
          rf_we     = 1'b1;
          rf_wdata  = mem_rdata;
          pc_inc    = 1'b1;
          done      = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        mem_addr = ry_val;
        if (opcode == OP_ST) begin
          mem_we    = 1'b1;
          mem_wdata = rx_val;
        end
        if (mem_ready) begin
          rf_we     = (opcode == OP_LD);
          rf_wdata  = mem_rdata;
          done      = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_WB: begin
        rf_we     = 1'b1;
        rf_wdata  = g;
        done      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (!run) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir <= '0;
      g  <= '0;
    end else begin
      if (ir_load) ir <= mem_rdata;
      if (g_load)  g  <= alu_res;
    end
  end

  // The register write comes after the increment so a load into the PC wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      rf[PC_IDX] <= RESET_PC;
    end else begin
      if (pc_inc) rf[PC_IDX] <= pc + DATA_W'(1);
      if (rf_we)  rf[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_param_multicycle_cpu.sv
// Directed bench for param_multicycle_cpu: a 16-bit/8-register instance with a
// stallable memory model plus a 32-bit/16-register instance on zero-wait memory.
`timescale 1ns/1ps
module tb_param_multicycle_cpu;

  localparam int OP_MV = 0, OP_MVI = 1, OP_ADD = 2, OP_SUB = 3, OP_LD = 4, OP_ST = 5;
  localparam int OP_MVNZ = 6, OP_AND = 7, OP_SLT = 8, OP_SLL = 9, OP_SRL = 10;
  localparam int OP_HALT = 11, OP_NOP = 12;

  // clock / reset
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic run     = 1'b0;
  logic run32   = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem_rdata, mem_addr, mem_wdata, pc;
  logic        mem_ready = 1'b1;
  logic        mem_req, mem_we, done, halted;
  logic [31:0] mem32_rdata, mem32_addr, mem32_wdata, pc32;
  logic        mem32_ready = 1'b1;
  logic        mem32_req, mem32_we, done32, halted32;

  logic [15:0] mem   [0:255];
  logic [31:0] mem32 [0:63];

  param_multicycle_cpu #(.DATA_W(16), .REG_AW(3), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset_n(reset_n), .run(run),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .halted(halted), .pc(pc)
  );

  param_multicycle_cpu #(.DATA_W(32), .REG_AW(4), .RESET_PC(32'h0)) dut32 (
    .clk(clk), .reset_n(reset_n), .run(run32),
    .mem_rdata(mem32_rdata), .mem_ready(mem32_ready),
    .mem_req(mem32_req), .mem_we(mem32_we), .mem_addr(mem32_addr), .mem_wdata(mem32_wdata),
    .done(done32), .halted(halted32), .pc(pc32)
  );

  assign mem_rdata   = mem[mem_addr[7:0]];
  assign mem32_rdata = mem32[mem32_addr[5:0]];

  // scoreboard state
  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          done_q[$];
  int          done32_cnt = 0;
  int          wr_count   = 0;
  logic [15:0] wr_addr = '0, wr_data = '0;

  // stall model configuration (driven by the stimulus block)
  logic        stall_on  = 1'b0;
  logic [15:0] stall_a   = '0, stall_b = '0;
  int          stall_len = 7;
  int          wait_cnt  = 0;
  int          stable_err = 0, stall_seen = 0;
  logic [15:0] hold_addr = '0, hold_wdata = '0;
  logic        hold_we   = 1'b0;

  int start, base, z, d, se0, ss0, wb, b32;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset_n && done) done_q.push_back(cyc);
    if (reset_n && done32) done32_cnt <= done32_cnt + 1;
    if (reset_n && mem_req && mem_we && mem_ready) begin
      wr_count <= wr_count + 1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
  end

  // Memory ready: a request at a stall address is held off for stall_len cycles,
  // and the request must stay unchanged for the whole wait.
  always @(negedge clk) begin
    if (!mem_req) begin
      mem_ready = 1'b1;
      wait_cnt  = 0;
    end else if (wait_cnt > 0 && wait_cnt < stall_len) begin
      if (mem_addr !== hold_addr || mem_we !== hold_we || mem_wdata !== hold_wdata)
        stable_err++;
      mem_ready = 1'b0;
      wait_cnt++;
      stall_seen++;
    end else if (wait_cnt == 0 && stall_on && (mem_addr == stall_a || mem_addr == stall_b)) begin
      hold_addr  = mem_addr;
      hold_we    = mem_we;
      hold_wdata = mem_wdata;
      mem_ready  = 1'b0;
      wait_cnt   = 1;
      stall_seen++;
    end else begin
      if (wait_cnt > 0 && mem_addr !== hold_addr) stable_err++;
      mem_ready = 1'b1;
      wait_cnt  = 0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] enc(input int op, input int rx, input int ry);
    logic [15:0] w;
    w = 16'((op << 12) | (rx << 9) | (ry << 6));
    return w;
  endfunction

  function automatic logic [31:0] enc32(input int op, input int rx, input int ry);
    logic [31:0] w;
    w = 32'((op << 28) | (rx << 24) | (ry << 20));
    return w;
  endfunction

  function automatic int done_at(input int idx, input int st);
    if (idx < done_q.size()) return done_q[idx] - st;
    return -1;
  endfunction

  // driver tasks
  task automatic do_reset();
    run   = 1'b0;
    run32 = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic run_prog(input int budget, output int st, output int bs);
    bs = done_q.size();
    @(negedge clk);
    st  = cyc;
    run = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (halted) break;
    end
    check("halt_reached", halted, 1);
  endtask

  task automatic stop_run();
    run = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // reset state
    clear_mem();
    do_reset();
    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_done", done, 0);
    check("rst_halted", halted, 0);
    check("rst_pc", pc, 16'h0000);
    check("rst_state_idle", dut.state, 0);
    check("rst_ir", dut.ir, 0);

    // mvi R0,#5; mvi R1,#3; add R0,R1; halt
    mem[0] = enc(OP_MVI, 0, 0); mem[1] = 16'd5;
    mem[2] = enc(OP_MVI, 1, 0); mem[3] = 16'd3;
    mem[4] = enc(OP_ADD, 0, 1);
    mem[5] = enc(OP_HALT, 0, 0);
    run_prog(100, start, base);
    check("a_r0", dut.rf[0], 8);
    check("a_r1", dut.rf[1], 3);
    check("a_pc", pc, 6);
    check("a_done_count", done_q.size() - base, 4);
    check("a_mvi_cycles", done_at(base + 0, start), 3);
    check("a_add_done", done_at(base + 2, start), 9);
    check("a_halt_done", done_at(base + 3, start), 11);

    // halt -> idle on run=0, then restart from the current PC
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("a_idle_halted", halted, 0);
    check("a_idle_state", dut.state, 0);
    mem[6] = enc(OP_HALT, 0, 0);
    run_prog(50, start, base);
    check("restart_pc", pc, 7);
    check("restart_halt_cycles", done_at(base + 0, start), 2);
    check("restart_done_count", done_q.size() - base, 1);

    // sub wraps; mvnz sees G != 0
    do_reset();
    clear_mem();
    mem[0] = enc(OP_MVI, 2, 0); mem[1] = 16'd2;
    mem[2] = enc(OP_MVI, 3, 0); mem[3] = 16'd5;
    mem[4] = enc(OP_SUB, 2, 3);
    mem[5] = enc(OP_MVNZ, 4, 3);
    mem[6] = enc(OP_HALT, 0, 0);
    run_prog(100, start, base);
    check("b_sub_wrap", dut.rf[2], 16'hFFFD);
    check("b_g", dut.g, 16'hFFFD);
    check("b_mvnz_taken", dut.rf[4], 5);
    check("b_mvnz_cycles", done_at(base + 3, start), 11);

    // continue from PC=7: equal operands give G=0, mvnz leaves R4 alone
    stop_run();
    mem[7]  = enc(OP_MVI, 2, 0); mem[8]  = 16'd5;
    mem[9]  = enc(OP_MVI, 3, 0); mem[10] = 16'd5;
    mem[11] = enc(OP_MVI, 4, 0); mem[12] = 16'd9;
    mem[13] = enc(OP_SUB, 2, 3);
    mem[14] = enc(OP_MVNZ, 4, 3);
    mem[15] = enc(OP_HALT, 0, 0);
    run_prog(100, start, base);
    check("c_sub_zero", dut.rf[2], 0);
    check("c_mvnz_skip", dut.rf[4], 9);
    check("c_pc", pc, 16);

    // ld: zero-wait reference, then 7-cycle stalls on the fetch and data phases
    do_reset();
    clear_mem();
    mem[0] = enc(OP_MVI, 2, 0); mem[1] = 16'h0040;
    mem[2] = enc(OP_LD, 3, 2);
    mem[3] = enc(OP_HALT, 0, 0);
    mem[8'h40] = 16'h1234;
    run_prog(100, start, base);
    z = done_at(base + 1, start);
    check("ld_zero_wait_cycles", z, 6);
    check("ld_zero_wait_data", dut.rf[3], 16'h1234);
    do_reset();
    stall_a   = 16'h0002;
    stall_b   = 16'h0040;
    stall_len = 7;
    stall_on  = 1'b1;
    se0 = stable_err;
    ss0 = stall_seen;
    run_prog(200, start, base);
    stall_on = 1'b0;
    d = done_at(base + 1, start);
    check("ld_stall_data", dut.rf[3], 16'h1234);
    check("ld_stall_done", d, 20);
    check("ld_stall_delay", d - z, 14);
    check("ld_stall_stable", stable_err - se0, 0);
    check("ld_stall_cycles_seen", stall_seen - ss0, 14);

    // st R1,[R2]
    do_reset();
    clear_mem();
    mem[0] = enc(OP_MVI, 1, 0); mem[1] = 16'hABCD;
    mem[2] = enc(OP_MVI, 2, 0); mem[3] = 16'h0040;
    mem[4] = enc(OP_ST, 1, 2);
    mem[5] = enc(OP_HALT, 0, 0);
    wb = wr_count;
    run_prog(100, start, base);
    check("st_write_count", wr_count - wb, 1);
    check("st_addr", wr_addr, 16'h0040);
    check("st_wdata", wr_data, 16'hABCD);
    check("st_r1_kept", dut.rf[1], 16'hABCD);
    check("st_r2_kept", dut.rf[2], 16'h0040);
    check("st_cycles", done_at(base + 2, start), 9);

    // shifts, slt, and, jump through mv to PC
    do_reset();
    clear_mem();
    mem[0]  = enc(OP_MVI, 0, 0); mem[1]  = 16'd1;
    mem[2]  = enc(OP_MVI, 1, 0); mem[3]  = 16'd15;
    mem[4]  = enc(OP_SLL, 0, 1);
    mem[5]  = enc(OP_MVI, 2, 0); mem[6]  = 16'd1;
    mem[7]  = enc(OP_MVI, 3, 0); mem[8]  = 16'd16;
    mem[9]  = enc(OP_SLL, 2, 3);
    mem[10] = enc(OP_MVI, 4, 0); mem[11] = 16'h8000;
    mem[12] = enc(OP_MVI, 5, 0); mem[13] = 16'd3;
    mem[14] = enc(OP_SRL, 4, 5);
    mem[15] = enc(OP_SLT, 1, 4);
    mem[16] = enc(OP_MVI, 6, 0); mem[17] = 16'h1F0F;
    mem[18] = enc(OP_AND, 6, 4);
    mem[19] = enc(OP_MVI, 5, 0); mem[20] = 16'h0020;
    mem[21] = enc(OP_MV, 7, 5);
    mem[8'h20] = enc(OP_NOP, 0, 0);
    mem[8'h21] = enc(OP_HALT, 0, 0);
    run_prog(200, start, base);
    check("sll_15", dut.rf[0], 16'h8000);
    check("sll_16_zero", dut.rf[2], 16'h0000);
    check("srl_3", dut.rf[4], 16'h1000);
    check("slt_true", dut.rf[1], 16'h0001);
    check("and", dut.rf[6], 16'h1000);
    check("jump_pc", pc, 16'h0022);
    check("shift_done_count", done_q.size() - base, 16);

    // reset asserted in the middle of a stalled ld data phase
    do_reset();
    clear_mem();
    mem[0] = enc(OP_MVI, 2, 0); mem[1] = 16'h0040;
    mem[2] = enc(OP_MVI, 3, 0); mem[3] = 16'd7;
    mem[4] = enc(OP_LD, 3, 2);
    stall_a   = 16'h0040;
    stall_b   = 16'h0040;
    stall_len = 1000;
    stall_on  = 1'b1;
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 16'h0040) break;
    end
    check("rm_in_mem", mem_addr, 16'h0040);
    repeat (3) @(negedge clk);
    check("rm_stalled_req", mem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rm_mem_req", mem_req, 0);
    check("rm_mem_addr", mem_addr, 0);
    check("rm_done", done, 0);
    check("rm_pc", pc, 16'h0000);
    check("rm_state_idle", dut.state, 0);
    check("rm_r2", dut.rf[2], 0);
    check("rm_r3", dut.rf[3], 0);
    run      = 1'b0;
    stall_on = 1'b0;
    stall_len = 7;
    @(negedge clk);
    reset_n = 1'b1;

    // 32-bit / 16-register build running the first program
    do_reset();
    for (int i = 0; i < 64; i++) mem32[i] = '0;
    mem32[0] = enc32(OP_MVI, 0, 0); mem32[1] = 32'd5;
    mem32[2] = enc32(OP_MVI, 1, 0); mem32[3] = 32'd3;
    mem32[4] = enc32(OP_ADD, 0, 1);
    mem32[5] = enc32(OP_HALT, 0, 0);
    @(negedge clk);
    b32   = done32_cnt;
    run32 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (halted32) break;
    end
    check("w32_halted", halted32, 1);
    check("w32_r0", dut32.rf[0], 8);
    check("w32_r1", dut32.rf[1], 3);
    check("w32_pc", pc32, 6);
    check("w32_r15_is_pc", dut32.rf[15], 6);
    check("w32_done_count", done32_cnt - b32, 4);
    run32 = 1'b0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
